// File: rtl/lzc_iter_normalizer.sv
// Iterative leading-zero counter / left normalizer, binary search one halving step per cycle.
// Latency: W cycles from accept to out_valid; throughput one word per W+2 cycles, no overlap.
// Backpressure: result holds bit-stable in DONE until out_ready; in_ready low while busy or holding.
module lzc_iter_normalizer #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_lzc,
  output logic [N-1:0] out_norm,
  output logic         out_zero
);

  localparam int SW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   word_r;
  logic [W:0]     cnt_r;
  logic [SW-1:0]  step_r;

  logic [W:0]     half;
  logic [N-1:0]   top_mask;
  logic           top_zero;
  logic           last_step;

  // Step k examines the top N>>(k+1) bits of the partially normalized word.
  assign half      = (W+1)'(N/2) >> step_r;
  assign top_mask  = ~({N{1'b1}} >> half);
  assign top_zero  = (word_r & top_mask) == '0;
  assign last_step = step_r == SW'(W-1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_zero  = 1'b0;
    out_lzc   = '0;
    out_norm  = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // After all halvings a nonzero word always has its MSB set.
        out_zero  = ~word_r[N-1];
        out_lzc   = word_r[N-1] ? cnt_r : (W+1)'(N);
        out_norm  = word_r;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= '0;
      cnt_r  <= '0;
      step_r <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            word_r <= in_word;
            cnt_r  <= '0;
            step_r <= '0;
          end
        end
        BUSY: begin
          if (top_zero) begin
            word_r <= word_r << half;
            cnt_r  <= cnt_r + half;
          end
          step_r <= last_step ? '0 : step_r + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
